fifo_drain_reader: RTL and testbench

FIFO_DRAIN_READER -- requirements
Module: fifo_drain_reader

---
 rtl/fifo_reader_pkg.sv | 16 +
 rtl/fifo_reader_skid.sv | 49 ++++
 rtl/fifo_drain_reader.sv | 128 ++++++++++++
 tb/tb_fifo_drain_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO drain reader.
// State encoding and the population-width helper.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    DRAIN     = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  function automatic int pop_width(input int capacity);
    return $clog2(capacity + 1);
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order skid buffer catching FIFO read data.
// clear has priority over push; pops on empty are ignored.
module fifo_reader_skid #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 read_clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 push,
  input  logic [BIT_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [BIT_WIDTH-1:0] head,
  output logic [1:0]           count
);

  logic [BIT_WIDTH-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic                 pop_ok;
  logic                 push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/fifo_drain_reader.sv
// Burst reader draining a mixed-clock FIFO into a skid buffer.
// Optional FIFO_DRAIN_READER_CHECKSUM_EN adds a running checksum.
module fifo_drain_reader
  import fifo_reader_pkg::*;
#(
  parameter int CAPACITY  = 5,
  parameter int BIT_WIDTH = 16,
  parameter int BURST     = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                           read_clock,
  input  logic                           reset_n,
  input  logic [BIT_WIDTH-1:0]           fifo_data_out,
  input  logic [pop_width(CAPACITY)-1:0] fifo_population,
  input  logic                           fifo_empty,
  output logic                           dequeue,
  output logic                           flush,
  input  logic                           flush_request,
  output logic [BIT_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [1:0]                     state,
  output logic [15:0]                    words_read
`ifdef FIFO_DRAIN_READER_CHECKSUM_EN
  ,
  output logic [BIT_WIDTH-1:0]           checksum
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BURST + 1);

  state_t          cur;
  state_t          nxt;
  logic [TW-1:0]   timer;
  logic [BW-1:0]   burst_cnt;
  logic            in_flight;
  logic [1:0]      skid_count;
  logic            room;
  logic            xfer;
  logic            fill_ok;

  assign state   = cur;
  assign xfer    = out_valid && out_ready;
  assign fill_ok = 32'(fifo_population) >= 32'(BURST);

  // Room counts words already in flight so the skid never overflows.
  assign room = (skid_count == 2'd0)
             || ((skid_count == 2'd1) && !in_flight);

  always_comb begin
    nxt     = cur;
    dequeue = 1'b0;
    flush   = 1'b0;
    unique case (cur)
      IDLE: begin
        if (!fifo_empty) nxt = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (fifo_empty) nxt = IDLE;
        else if (fill_ok || (timer == TW'(TIMEOUT - 1)))
          nxt = DRAIN;
      end
      DRAIN: begin
        dequeue = !fifo_empty && room;
        if (dequeue && (burst_cnt == BW'(BURST - 1)))
          nxt = IDLE;
        else if (fifo_empty)
          nxt = IDLE;
      end
      FLUSH: begin
        flush = 1'b1;
        nxt   = IDLE;
      end
    endcase
    if (flush_request) nxt = FLUSH;
  end

  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      cur       <= IDLE;
      timer     <= '0;
      burst_cnt <= '0;
      in_flight <= 1'b0;
    end else begin
      cur       <= nxt;
      timer     <= (cur == WAIT_FILL) ? timer + 1'b1 : '0;
      burst_cnt <= (cur == DRAIN) ? burst_cnt + BW'(dequeue) : '0;
      in_flight <= dequeue;
    end
  end

  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      words_read <= 16'd0;
    end else if (xfer) begin
      words_read <= words_read + 16'd1;
    end
  end

  fifo_reader_skid #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_skid (
    .read_clock (read_clock),
    .reset_n    (reset_n),
    .clear      (cur == FLUSH),
    .push       (in_flight),
    .push_data  (fifo_data_out),
    .pop        (out_ready),
    .head       (out_data),
    .count      (skid_count)
  );

  assign out_valid = (skid_count != 2'd0);

`ifdef FIFO_DRAIN_READER_CHECKSUM_EN
  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (cur == FLUSH) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Directed bench for fifo_drain_reader with a queue-based FIFO model.
// Define FIFO_DRAIN_READER_CHECKSUM_EN to cover the checksum output.
module tb_fifo_drain_reader;

  localparam int W = 16;

  logic          read_clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [W-1:0]  fifo_data_out = '0;
  logic [2:0]    fifo_population = 3'd0;
  logic          fifo_empty = 1'b1;
  logic          dequeue;
  logic          flush;
  logic          flush_request = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    state;
  logic [15:0]   words_read;
`ifdef FIFO_DRAIN_READER_CHECKSUM_EN
  logic [W-1:0]  checksum;
`endif

  int checks = 0;
  int errors = 0;
  int deq_cnt = 0;
  int wf_cnt = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] load_q[$];
  logic [W-1:0] got[$];

  always #5 read_clock = ~read_clock;

  fifo_drain_reader dut (
    .read_clock      (read_clock),
    .reset_n         (reset_n),
    .fifo_data_out   (fifo_data_out),
    .fifo_population (fifo_population),
    .fifo_empty      (fifo_empty),
    .dequeue         (dequeue),
    .flush           (flush),
    .flush_request   (flush_request),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .state           (state),
    .words_read      (words_read)
`ifdef FIFO_DRAIN_READER_CHECKSUM_EN
    ,
    .checksum        (checksum)
`endif
  );

  // FIFO model: one-cycle read latency, flush empties it.
  always @(posedge read_clock) begin
    if (flush) q.delete();
    else if (dequeue && q.size() != 0) fifo_data_out <= q.pop_front();
    while (load_q.size() != 0) q.push_back(load_q.pop_front());
    fifo_population <= 3'(q.size());
    fifo_empty      <= (q.size() == 0);
  end

  always @(posedge read_clock) begin
    if (reset_n) begin
      if (dequeue) deq_cnt <= deq_cnt + 1;
      if (state == 2'd1) wf_cnt <= wf_cnt + 1;
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge read_clock);
    reset_n = 1'b0;
    out_ready = 1'b0;
    flush_request = 1'b0;
    q.delete();
    load_q.delete();
    @(negedge read_clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int b_deq;
    int b_wf;
    int b_got;

    #1 reset_n = 1'b0;
    #2;
    check("rst_state", state, 0);
    check("rst_deq", dequeue, 0);
    check("rst_flush", flush, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_words", words_read, 0);
    @(negedge read_clock);
    @(negedge read_clock);
    reset_n = 1'b1;

    // Full burst of four.
    @(negedge read_clock);
    b_deq = deq_cnt; b_wf = wf_cnt; b_got = got.size();
    out_ready = 1'b1;
    load_q.push_back(16'd10000);
    load_q.push_back(16'd20000);
    load_q.push_back(16'd30000);
    load_q.push_back(16'd40000);
    n = 0;
    while (state !== 2'd2 && n < 10) begin @(negedge read_clock); n++; end
    check("b4_drain", state, 2);
    n = 0;
    while (!(state === 2'd0 && out_valid === 1'b0) && n < 20) begin
      @(negedge read_clock); n++;
    end
    check("b4_idle", state, 0);
    check("b4_wfcyc", wf_cnt - b_wf, 1);
    check("b4_deqs", deq_cnt - b_deq, 4);
    check("b4_n", got.size() - b_got, 4);
    check("b4_w0", got[b_got], 10000);
    check("b4_w1", got[b_got+1], 20000);
    check("b4_w2", got[b_got+2], 30000);
    check("b4_w3", got[b_got+3], 40000);
    check("b4_words", words_read, 4);
    check("b4_pop", fifo_population, 0);
`ifdef FIFO_DRAIN_READER_CHECKSUM_EN
    check("b4_csum", checksum, 34464);
`endif

    // Flush with a read in flight.
    b_got = got.size();
    load_q.push_back(16'd7);
    load_q.push_back(16'd8);
    load_q.push_back(16'd9);
    load_q.push_back(16'd10);
    n = 0;
    while (dequeue !== 1'b1 && n < 10) begin @(negedge read_clock); n++; end
    check("fl_deq", dequeue, 1);
    flush_request = 1'b1;
    @(negedge read_clock);
    flush_request = 1'b0;
    check("fl_state", state, 3);
    check("fl_flush", flush, 1);
    check("fl_nodeq", dequeue, 0);
    @(negedge read_clock);
    check("fl_flush0", flush, 0);
    check("fl_valid0", out_valid, 0);
    check("fl_idle", state, 0);
    repeat (5) @(negedge read_clock);
    check("fl_noout", got.size() - b_got, 0);
    check("fl_words", words_read, 4);
`ifdef FIFO_DRAIN_READER_CHECKSUM_EN
    check("fl_csum", checksum, 0);
`endif

    // Single word waits for the timeout.
    do_reset();
    b_deq = deq_cnt; b_wf = wf_cnt; b_got = got.size();
    out_ready = 1'b1;
    load_q.push_back(16'd500);
    n = 0;
    while (state !== 2'd2 && n < 30) begin @(negedge read_clock); n++; end
    check("to_drain", state, 2);
    check("to_wfcyc", wf_cnt - b_wf, 15);
    check("to_nodeq", deq_cnt - b_deq, 0);
    n = 0;
    while (got.size() < b_got + 1 && n < 10) begin @(negedge read_clock); n++; end
    check("to_n", got.size() - b_got, 1);
    check("to_w0", got[b_got], 500);
    check("to_words", words_read, 1);

    // Backpressure: only two reads, then the rest in order.
    do_reset();
    b_deq = deq_cnt; b_got = got.size();
    for (int i = 0; i < 5; i++) load_q.push_back(16'(1001 + i));
    repeat (14) @(negedge read_clock);
    check("bp_deqs", deq_cnt - b_deq, 2);
    check("bp_pop", fifo_population, 3);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 1001);
    check("bp_words0", words_read, 0);
    out_ready = 1'b1;
    n = 0;
    while (got.size() < b_got + 5 && n < 60) begin @(negedge read_clock); n++; end
    check("bp_n", got.size() - b_got, 5);
    for (int i = 0; i < 5; i++) check("bp_word", got[b_got+i], 1001 + i);
    check("bp_words", words_read, 5);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) load_q.push_back(16'(i + 1));
    n = 0;
    while (!(state === 2'd2 && out_valid === 1'b1 && words_read != 0) && n < 20) begin
      @(negedge read_clock); n++;
    end
    check("mr_mid", (state == 2'd2) && out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_state", state, 0);
    check("mr_deq", dequeue, 0);
    check("mr_flush", flush, 0);
    check("mr_valid", out_valid, 0);
    check("mr_data", out_data, 0);
    check("mr_words", words_read, 0);
    @(negedge read_clock);
    reset_n = 1'b1;
    @(negedge read_clock);
    check("mr_post", state, 1);
    check("mr_pvalid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
